// File: rtl/board_pkg.sv
`default_nettype none
// ============================================================================
// Module      : board_pkg
// Description : Board-level constants and shared types for the LED channel
//               router: LED bank width, default channel count, debounce
//               lengths for simulation and hardware, and the channel-step
//               decode used by the channel state machine.
// Revision    : 1.0 - initial release
// ============================================================================
package board_pkg;

  localparam int LED_WIDTH           = 3;
  localparam int NUM_CH_DEFAULT      = 4;
  localparam int DEBOUNCE_CYCLES_SIM = 4;
  localparam int DEBOUNCE_CYCLES_HW  = 250000;

  // Net channel movement requested in one cycle.
  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_NEXT = 2'd1,
    STEP_PREV = 2'd2
  } ch_step_e;

  // Simultaneous next and prev presses cancel each other out.
  function automatic ch_step_e step_from_events(input logic next_ev,
                                                input logic prev_ev);
    ch_step_e step;
    step = STEP_HOLD;
    if (next_ev && !prev_ev) begin
      step = STEP_NEXT;
    end else if (prev_ev && !next_ev) begin
      step = STEP_PREV;
    end
    return step;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Push-button conditioner: 2-FF synchronizer, stability
//               counter and rising-edge press pulse.
// Ports       : clk   - system clock
//               rst   - asynchronous active-high reset
//               btn   - raw (asynchronous, bouncy) button level
//               press - one-cycle pulse when the debounced level rises
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
  import board_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_HW
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      level  <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_1 <= btn;
      sync_2 <= sync_1;
      press  <= 1'b0;
      if (sync_2 == level) begin
        // Any agreeing sample restarts the stability window.
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        // DEBOUNCE_CYCLES consecutive disagreeing samples: accept the level.
        level <= sync_2;
        cnt   <= '0;
        press <= sync_2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_channel_router.sv
`default_nettype none
// ============================================================================
// Module      : led_channel_router
// Description : Routes a WIDTH-bit switch value into one of NUM_CH registered
//               LED banks. The active bank is stepped by debounced next/prev
//               buttons with wrap-around in both directions; freeze stops all
//               capture without affecting channel selection.
// Ports       : clk           - system clock
//               rst           - asynchronous active-high reset
//               sel           - switch value captured into the active bank
//               btn_next      - raw button, press selects channel+1
//               btn_prev      - raw button, press selects channel-1
//               freeze        - 1 = no bank is written
//               leds          - bank k at bits [k*WIDTH +: WIDTH]
//               active_ch     - currently selected bank index
//               active_onehot - one-hot decode of active_ch
// Revision    : 1.0 - initial release
// ============================================================================
module led_channel_router
  import board_pkg::*;
#(
  parameter  int WIDTH           = LED_WIDTH,
  parameter  int NUM_CH          = NUM_CH_DEFAULT,
  parameter  int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_HW,
  localparam int CH_W            = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        sel,
  input  logic                    btn_next,
  input  logic                    btn_prev,
  input  logic                    freeze,
  output logic [NUM_CH*WIDTH-1:0] leds,
  output logic [CH_W-1:0]         active_ch,
  output logic [NUM_CH-1:0]       active_onehot
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  // Reset asserts immediately but releases only on a clk edge, so no flop
  // sees a reset deassertion near its active edge.
  logic [1:0] rst_pipe;
  logic       rst_int;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_pipe <= 2'b11;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b0};
    end
  end

  assign rst_int = rst_pipe[1];

  logic next_ev;
  logic prev_ev;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_db_next (
    .clk   (clk),
    .rst   (rst_int),
    .btn   (btn_next),
    .press (next_ev)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_db_prev (
    .clk   (clk),
    .rst   (rst_int),
    .btn   (btn_prev),
    .press (prev_ev)
  );

  // Next-channel decode. Wrap uses explicit compares so non-power-of-2
  // channel counts never reach an unused index.
  ch_step_e          step;
  logic [CH_W-1:0]   ch_nxt;
  logic [NUM_CH-1:0] onehot_nxt;

  always_comb begin
    step   = step_from_events(next_ev, prev_ev);
    ch_nxt = active_ch;
    case (step)
      STEP_NEXT: ch_nxt = (active_ch == LAST_CH) ? '0 : active_ch + CH_W'(1);
      STEP_PREV: ch_nxt = (active_ch == '0) ? LAST_CH : active_ch - CH_W'(1);
      default:   ch_nxt = active_ch;
    endcase
    onehot_nxt = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      onehot_nxt[k] = (ch_nxt == CH_W'(k));
    end
  end

  // Channel state machine: state is active_ch itself, decoded one-hot
  // alongside it so both outputs change on the same edge.
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      active_ch     <= '0;
      active_onehot <= NUM_CH'(1);
    end else begin
      active_ch     <= ch_nxt;
      active_onehot <= onehot_nxt;
    end
  end

  // Bank capture uses the pre-edge channel, so on a channel-change cycle the
  // outgoing bank takes this cycle's sel.
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      leds <= '0;
    end else if (!freeze) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (active_ch == CH_W'(k)) begin
          leds[k*WIDTH +: WIDTH] <= sel;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_channel_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_channel_router
// Description : Self-checking bench for led_channel_router. Two instances
//               (4 and 3 channels) share stimulus; a behavioural model
//               predicts every post-edge output and a monitor compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_channel_router;

  localparam int W  = 3;
  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  sel = '0;
  logic        btn_next = 1'b0;
  logic        btn_prev = 1'b0;
  logic        freeze = 1'b0;
  logic [11:0] leds0;
  logic [1:0]  ch0;
  logic [3:0]  oh0;
  logic [8:0]  leds1;
  logic [1:0]  ch1;
  logic [2:0]  oh1;

  always #5 clk = ~clk;

  led_channel_router #(.WIDTH(W), .NUM_CH(4), .DEBOUNCE_CYCLES(DB)) dut4 (
    .clk(clk), .rst(rst), .sel(sel), .btn_next(btn_next), .btn_prev(btn_prev),
    .freeze(freeze), .leds(leds0), .active_ch(ch0), .active_onehot(oh0)
  );

  led_channel_router #(.WIDTH(W), .NUM_CH(3), .DEBOUNCE_CYCLES(DB)) dut3 (
    .clk(clk), .rst(rst), .sel(sel), .btn_next(btn_next), .btn_prev(btn_prev),
    .freeze(freeze), .leds(leds1), .active_ch(ch1), .active_onehot(oh1)
  );

  typedef struct {
    logic [11:0] l0;
    logic [1:0]  c0;
    logic [3:0]  o0;
    logic [8:0]  l1;
    logic [1:0]  c1;
    logic [2:0]  o1;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    tests++;
    if (got !== want) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Buttons: raw level reaches the debouncer after two sampling edges; a
  // level change is accepted after DB consecutive disagreeing samples, and a
  // rising acceptance moves the channel one edge later.
  int nch[2] = '{4, 3};
  int ch_m[2];
  int bank[2][4];
  bit s1[2], s2[2], lvl[2], evt[2];
  int run[2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      ch_m[d] = 0;
      for (int k = 0; k < 4; k++) bank[d][k] = 0;
    end
    for (int b = 0; b < 2; b++) begin
      s1[b] = 0; s2[b] = 0; lvl[b] = 0; evt[b] = 0; run[b] = 0;
    end
  endtask

  task automatic model_step(input int sv, input bit n, input bit p, input bit frz);
    bit raw[2];
    bit s;
    bit newev[2];
    exp_t e;
    raw[0] = n; raw[1] = p;
    for (int d = 0; d < 2; d++) begin
      if (!frz) bank[d][ch_m[d]] = sv;
      if (evt[0] && !evt[1])      ch_m[d] = (ch_m[d] + 1) % nch[d];
      else if (evt[1] && !evt[0]) ch_m[d] = (ch_m[d] + nch[d] - 1) % nch[d];
    end
    for (int b = 0; b < 2; b++) begin
      s = s2[b]; s2[b] = s1[b]; s1[b] = raw[b];
      newev[b] = 0;
      if (s != lvl[b]) begin
        run[b]++;
        if (run[b] == DB) begin
          lvl[b] = s; run[b] = 0; newev[b] = s;
        end
      end else begin
        run[b] = 0;
      end
    end
    evt = newev;
    e.l0 = '0; e.l1 = '0;
    for (int k = 0; k < 4; k++) e.l0 = e.l0 | 12'(bank[0][k] << (3*k));
    for (int k = 0; k < 3; k++) e.l1 = e.l1 | 9'(bank[1][k] << (3*k));
    e.c0 = 2'(ch_m[0]); e.o0 = 4'(1 << ch_m[0]);
    e.c1 = 2'(ch_m[1]); e.o1 = 3'(1 << ch_m[1]);
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("leds4", 32'(leds0), 32'(e.l0));
        check("ch4",   32'(ch0),   32'(e.c0));
        check("oh4",   32'(oh0),   32'(e.o0));
        check("leds3", 32'(leds1), 32'(e.l1));
        check("ch3",   32'(ch1),   32'(e.c1));
        check("oh3",   32'(oh1),   32'(e.o1));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle(input int sv, input bit n, input bit p, input bit frz);
    sel = 3'(sv); btn_next = n; btn_prev = p; freeze = frz;
    @(posedge clk);
    #1;
    model_step(sv, n, p, frz);
  endtask

  task automatic do_reset(input bit hold_next);
    @(negedge clk);
    #1;
    btn_next = hold_next; btn_prev = 1'b0; freeze = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_leds4", 32'(leds0), 32'h0);
    check("rst_ch4",   32'(ch0),   32'h0);
    check("rst_oh4",   32'(oh0),   32'h1);
    check("rst_leds3", 32'(leds1), 32'h0);
    check("rst_ch3",   32'(ch1),   32'h0);
    check("rst_oh3",   32'(oh1),   32'h1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    // Internal reset releases on the second edge after rst falls.
    repeat (2) @(posedge clk);
    #1;
    model_reset();
  endtask

  task automatic press(input bit n, input bit p);
    repeat (8) cycle($urandom_range(7), n, p, 0);
    repeat (8) cycle($urandom_range(7), 0, 0, 0);
  endtask

  initial begin
    bit rn, rp;
    model_reset();
    rst = 1'b1;
    #2;
    do_reset(0);

    // Basic capture.
    repeat (2) cycle(5, 0, 0, 0);

    // Clean press, then capture into the new channel.
    repeat (10) cycle(5, 1, 0, 0);
    repeat (10) cycle(3, 0, 0, 0);

    // Bouncing button, then held.
    for (int i = 0; i < 20; i++) cycle(6, i[0], 0, 0);
    repeat (10) cycle(2, 1, 0, 0);
    repeat (10) cycle(4, 0, 0, 0);

    // Wrap in both directions.
    do_reset(0);
    press(0, 1);
    repeat (4) press(1, 0);
    press(0, 1);

    // Simultaneous presses cancel; freeze holds all banks.
    press(1, 1);
    for (int v = 0; v < 8; v++) cycle(v, 0, 0, 1);
    press(1, 0);
    for (int v = 0; v < 8; v++) cycle(7 - v, 0, 0, 1);

    // Reset mid-debounce, reset after capture, press held through reset.
    repeat (3) cycle(1, 1, 0, 0);
    do_reset(1);
    repeat (2) cycle(6, 1, 0, 0);
    do_reset(1);
    repeat (12) cycle(2, 1, 0, 0);
    repeat (10) cycle(7, 0, 0, 0);

    // Randomized traffic with slowly changing button levels.
    rn = 0; rp = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(5) == 0) rn = ~rn;
      if ($urandom_range(5) == 0) rp = ~rp;
      cycle($urandom_range(7), rn, rp, $urandom_range(3) == 0);
    end

    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_channel_router.md
Name: led_channel_router

Overview:
- Parametrised successor to the two-bank switch selector. Routes a WIDTH-bit switch value into one of NUM_CH registered LED banks.
- The active bank is chosen by debounced next/prev push-buttons; the channel index wraps in both directions.
- Non-active banks hold their last captured value. A freeze input stops capture without changing the channel.
- Sits between board switch/button pins and the LED output pins.

Parameters:
- WIDTH, 3, bits per LED bank and width of the sel input.
- NUM_CH, 4, number of LED banks (2..16).
- DEBOUNCE_CYCLES, 250000, consecutive stable synchronized samples required to accept a button level change (>=2).
- CH_W, $clog2(NUM_CH), localparam, width of the channel index.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- sel  input  WIDTH  switch value to capture.
- btn_next  input  1  raw button; each accepted press selects channel+1.
- btn_prev  input  1  raw button; each accepted press selects channel-1.
- freeze  input  1  1 = no bank is written.
- leds  output  NUM_CH*WIDTH  bank k occupies bits [k*WIDTH +: WIDTH].
- active_ch  output  CH_W  index of the currently selected bank.
- active_onehot  output  NUM_CH  one-hot decode of active_ch.

Behaviour:
- Reset (async assert; internally a clean deassert on the clk edge):
  - leds=0, active_ch=0, active_onehot=1.
  - Synchronizers, debounce counters and debounced levels = 0.
- Input synchronization: each button passes through a 2-FF synchronizer.
- Debounce, per button:
  - Counter increments while the synchronized level differs from the debounced level; it clears whenever the two are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes the synchronized level and the counter clears.
- Press event: a one-cycle pulse on the 0->1 transition of a debounced level. Release produces no event. Holding a button yields exactly one event.
- Channel FSM (state = active_ch, NUM_CH states):
  - next event only: active_ch = (active_ch==NUM_CH-1) ? 0 : active_ch+1.
  - prev event only: active_ch = (active_ch==0) ? NUM_CH-1 : active_ch-1.
  - Both events in the same cycle: no change.
  - Wrap uses an explicit compare, so it is correct for non-power-of-2 NUM_CH.
- Capture:
  - Every cycle with freeze=0, bank[active_ch] <= sel, using the active_ch value before the edge. sel is a static switch and is not synchronized.
  - Latency: a sel change is visible on leds one clk later.
  - On a channel-change cycle, the old channel receives that cycle's sel; the new channel starts capturing on the next cycle.
  - freeze=1: all banks hold. Channel changes still occur.
- All outputs are registered; active_onehot is registered alongside active_ch.
- Reset asserted mid-debounce or mid-capture: everything returns to reset values immediately. A press held through reset release is accepted only after it has been stable for DEBOUNCE_CYCLES with the debounced level starting at 0, so it produces one event.
- No latches: every combinational path assigns all outputs in all branches.

Decomposition:
- Shared package (board_pkg): LED_WIDTH=3, default NUM_CH=4, DEBOUNCE_CYCLES_SIM=4, DEBOUNCE_CYCLES_HW=250000.
- One sub-module, btn_debounce: synchronizer + debounce counter + rising-edge pulse, parameter DEBOUNCE_CYCLES. Instantiated twice.
- The top level holds the channel FSM and the bank register array.

Test Plan (DEBOUNCE_CYCLES=4, NUM_CH=4, WIDTH=3):
1. Reset, then sel=3'b101 for 2 cycles -> leds=12'h005, active_ch=0, active_onehot=4'b0001.
2. Clean btn_next pulse held 10 cycles, then sel=3'b011 -> exactly one event; active_ch=1; bank1=3, bank0 holds 5.
3. btn_next toggled every cycle for 20 cycles (bounce) then held high -> exactly one event; after bounce, active_ch advances by 1 only.
4. From active_ch=0, one btn_prev press -> active_ch=3. Then 4 btn_next presses -> visits 0,1,2,3, ending at 3 (wrap both ways). Repeat with NUM_CH=3: 2 -> 0.
5. btn_next and btn_prev rise on the same cycle and stay high -> both events coincide; active_ch unchanged. freeze=1 with sel changing 0..7 -> leds unchanged.
6. rst pulsed high mid-debounce and again 2 cycles after a capture -> leds=0 and active_ch=0 asynchronously. The held button is accepted once after release.
